plot_capture: RTL and testbench

PLOT_CAPTURE -- requirements
Module: plot_capture

---
 rtl/plot_capture.sv | 208 ++++++++++++++++++++
 tb/tb_plot_capture.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plot_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | plot_capture: queues pixel plots into a 160x120x3 frame memory, with a   |
// | full-frame clear engine and a single-cycle-latency pixel readback port.  |
// | Optional: `define PLOT_CAPTURE_CLIP_EN drops plots outside 160x120.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module plot_capture (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  vga_x,
   input  logic [6:0]  vga_y,
   input  logic [2:0]  vga_colour,
   input  logic        vga_plot,
   output logic        plot_ready,
   input  logic        clear_start,
   input  logic [2:0]  clear_colour,
   output logic        clear_done,
   input  logic        rd_en,
   input  logic [7:0]  rd_x,
   input  logic [6:0]  rd_y,
   output logic [2:0]  rd_colour,
   output logic        rd_valid,
   output logic [14:0] pixel_count,
   output logic [7:0]  drop_count,
   output logic        busy
);

   localparam int unsigned c_FB_DEPTH  = 19200;
   localparam logic [14:0] c_FB_SIZE   = 15'd19200;
   localparam logic [14:0] c_LAST_ADDR = 15'd19199;
   localparam logic [14:0] c_PIX_MAX   = 15'd32767;
   localparam logic [7:0]  c_DROP_MAX  = 8'd255;

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [17:0] r_fifo [0:7];
   logic [2:0]  r_wr_ptr;
   logic [2:0]  r_rd_ptr;
   logic [3:0]  r_count;

   logic [14:0] r_clr_addr;
   logic [2:0]  r_clr_colour;
   logic        r_clear_done;
   logic        r_rd_valid;
   logic [2:0]  r_mem_q;
   logic [14:0] r_pixel_count;
   logic [7:0]  r_drop_count;
   logic [2:0]  r_mem [0:c_FB_DEPTH-1];

   logic        w_in_range;
   logic        w_accept;
   logic        w_drain;
   logic        w_rd_go;
   logic        w_clr_go;
   logic        w_clr_last;
   logic        w_mem_we;
   logic [14:0] w_mem_addr;
   logic [2:0]  w_mem_wdata;
   logic [17:0] w_head;
   logic [14:0] w_head_addr;
   logic [14:0] w_rd_addr;

   // y*160 + x built from shifts: y*128 + y*32 + x
   function automatic logic [14:0] f_addr(input logic [7:0] x, input logic [6:0] y);
      return {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};
   endfunction

`ifdef PLOT_CAPTURE_CLIP_EN
   assign w_in_range = (vga_x < 8'd160) && (vga_y < 7'd120);
`else
   assign w_in_range = 1'b1;
`endif

   assign plot_ready  = ~r_count[3];
   assign w_accept    = vga_plot && plot_ready && w_in_range;
   assign w_head      = r_fifo[r_rd_ptr];
   assign w_head_addr = f_addr(w_head[17:10], w_head[9:3]);
   assign w_rd_addr   = f_addr(rd_x, rd_y);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_rd_go     = 1'b0;
      w_drain     = 1'b0;
      w_clr_go    = 1'b0;
      w_clr_last  = 1'b0;
      case (r_state)
         ST_RUN: begin
            w_rd_go = rd_en;
            w_drain = !rd_en && (r_count != 4'd0);
            if (clear_start) begin
               w_clr_go    = 1'b1;
               w_state_nxt = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            w_clr_last = (r_clr_addr == c_LAST_ADDR);
            if (w_clr_last) begin
               w_state_nxt = ST_RUN;
            end
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   // One shared memory port: clear engine, else readback, else FIFO drain
   always_comb begin
      w_mem_we    = 1'b0;
      w_mem_addr  = w_head_addr;
      w_mem_wdata = w_head[2:0];
      if (r_state == ST_CLEAR) begin
         w_mem_we    = 1'b1;
         w_mem_addr  = r_clr_addr;
         w_mem_wdata = r_clr_colour;
      end else if (w_rd_go) begin
         w_mem_addr  = w_rd_addr;
      end else if (w_drain) begin
         w_mem_we    = (w_head_addr < c_FB_SIZE);
      end
   end

   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_mem_addr] <= w_mem_wdata;
      end
      if (w_rd_go) begin
         r_mem_q <= (w_mem_addr < c_FB_SIZE) ? r_mem[w_mem_addr] : 3'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_fifo[r_wr_ptr] <= {vga_x, vga_y, vga_colour};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= 3'd0;
         r_rd_ptr <= 3'd0;
         r_count  <= 4'd0;
      end else begin
         if (w_accept) begin
            r_wr_ptr <= r_wr_ptr + 3'd1;
         end
         if (w_drain) begin
            r_rd_ptr <= r_rd_ptr + 3'd1;
         end
         case ({w_accept, w_drain})
            2'b10:   r_count <= r_count + 4'd1;
            2'b01:   r_count <= r_count - 4'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_clr_addr    <= 15'd0;
         r_clr_colour  <= 3'd0;
         r_clear_done  <= 1'b0;
         r_rd_valid    <= 1'b0;
         r_pixel_count <= 15'd0;
         r_drop_count  <= 8'd0;
      end else begin
         r_clear_done <= w_clr_last;
         r_rd_valid   <= w_rd_go;
         if (w_clr_go) begin
            r_clr_addr   <= 15'd0;
            r_clr_colour <= clear_colour;
         end else if (r_state == ST_CLEAR) begin
            r_clr_addr <= r_clr_addr + 15'd1;
         end
         // A clear request zeroes the count even if a drain write shares its cycle
         if (w_clr_go) begin
            r_pixel_count <= 15'd0;
         end else if (w_drain && (r_pixel_count != c_PIX_MAX)) begin
            r_pixel_count <= r_pixel_count + 15'd1;
         end
         if (vga_plot && !w_accept && (r_drop_count != c_DROP_MAX)) begin
            r_drop_count <= r_drop_count + 8'd1;
         end
      end
   end

   assign clear_done  = r_clear_done;
   assign rd_valid    = r_rd_valid;
   assign rd_colour   = r_rd_valid ? r_mem_q : 3'd0;
   assign pixel_count = r_pixel_count;
   assign drop_count  = r_drop_count;
   assign busy        = (r_state == ST_CLEAR) || (r_count != 4'd0);

endmodule
`default_nettype wire

// File: tb/tb_plot_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_plot_capture: randomized stimulus against a queue/array model of the  |
// | plot capture block, plus directed scenarios with literal expectations.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_plot_capture;

   logic        clk;
   logic        rst;
   logic [7:0]  vga_x;
   logic [6:0]  vga_y;
   logic [2:0]  vga_colour;
   logic        vga_plot;
   logic        plot_ready;
   logic        clear_start;
   logic [2:0]  clear_colour;
   logic        clear_done;
   logic        rd_en;
   logic [7:0]  rd_x;
   logic [6:0]  rd_y;
   logic [2:0]  rd_colour;
   logic        rd_valid;
   logic [14:0] pixel_count;
   logic [7:0]  drop_count;
   logic        busy;

   plot_capture dut (
      .clk          (clk),
      .rst          (rst),
      .vga_x        (vga_x),
      .vga_y        (vga_y),
      .vga_colour   (vga_colour),
      .vga_plot     (vga_plot),
      .plot_ready   (plot_ready),
      .clear_start  (clear_start),
      .clear_colour (clear_colour),
      .clear_done   (clear_done),
      .rd_en        (rd_en),
      .rd_x         (rd_x),
      .rd_y         (rd_y),
      .rd_colour    (rd_colour),
      .rd_valid     (rd_valid),
      .pixel_count  (pixel_count),
      .drop_count   (drop_count),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic cmp(input string nm, input int act, input int exp_v);
      n_cmp = n_cmp + 1;
      if (act != exp_v) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
      end
   endtask

   // Reference model: frame as a flat array, FIFO as a queue
   typedef struct {int x; int y; int c;} ent_t;
   ent_t     m_q[$];
   bit [2:0] m_mem   [19200];
   bit       m_known [19200];
   bit       m_in_clr;
   int       m_clr_i;
   int       m_clr_c;
   int       m_pix, m_drop;
   bit       m_done, m_rdv, m_rdk;
   int       m_rdc;

   always @(posedge clk or posedge rst) begin : mdl
      int   a;
      bit   acc;
      bit   ok;
      ent_t e;
      if (rst) begin
         m_q.delete();
         m_in_clr = 0; m_clr_i = 0; m_pix = 0; m_drop = 0;
         m_done = 0; m_rdv = 0; m_rdc = 0; m_rdk = 1;
      end else begin
`ifdef PLOT_CAPTURE_CLIP_EN
         ok = (vga_x < 160) && (vga_y < 120);
`else
         ok = 1'b1;
`endif
         acc = vga_plot && (m_q.size() < 8) && ok;
         if (vga_plot && !acc && m_drop < 255) m_drop = m_drop + 1;
         m_rdv = !m_in_clr && rd_en;
         m_rdc = 0;
         m_rdk = 1;
         if (m_rdv) begin
            a = int'(rd_y) * 160 + int'(rd_x);
            if (a < 19200) begin
               m_rdc = int'(m_mem[a]);
               m_rdk = m_known[a];
            end
         end
         m_done = 0;
         if (m_in_clr) begin
            m_mem[m_clr_i]   = m_clr_c[2:0];
            m_known[m_clr_i] = 1;
            m_clr_i = m_clr_i + 1;
            if (m_clr_i == 19200) begin
               m_in_clr = 0;
               m_done   = 1;
            end
         end else begin
            if (!rd_en && m_q.size() > 0) begin
               e = m_q.pop_front();
               a = e.y * 160 + e.x;
               if (a < 19200) begin
                  m_mem[a]   = e.c[2:0];
                  m_known[a] = 1;
               end
               if (m_pix < 32767) m_pix = m_pix + 1;
            end
            if (clear_start) begin
               m_clr_c  = int'(clear_colour);
               m_pix    = 0;
               m_in_clr = 1;
               m_clr_i  = 0;
            end
         end
         if (acc) begin
            e.x = int'(vga_x); e.y = int'(vga_y); e.c = int'(vga_colour);
            m_q.push_back(e);
         end
      end
   end

   always @(negedge clk) begin
      cmp("plot_ready", int'(plot_ready), (m_q.size() < 8) ? 1 : 0);
      cmp("busy", int'(busy), (m_in_clr || m_q.size() > 0) ? 1 : 0);
      cmp("clear_done", int'(clear_done), int'(m_done));
      cmp("rd_valid", int'(rd_valid), int'(m_rdv));
      if (m_rdk) cmp("rd_colour", int'(rd_colour), m_rdc);
      cmp("pixel_count", int'(pixel_count), m_pix);
      cmp("drop_count", int'(drop_count), m_drop);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_inputs();
      vga_plot   = ($urandom % 10) < 6;
      vga_x      = 8'($urandom_range(0, 170));
      vga_y      = 7'($urandom_range(0, 125));
      vga_colour = 3'($urandom);
      rd_en      = ($urandom % 10) < 3;
      rd_x       = 8'($urandom_range(0, 165));
      rd_y       = 7'($urandom_range(0, 121));
   endtask

   task automatic read_px(input int x, input int y, input int exp_c, input string nm);
      rd_en = 1; rd_x = 8'(x); rd_y = 7'(y);
      tick();
      rd_en = 0;
      cmp({nm, "_valid"}, int'(rd_valid), 1);
      cmp({nm, "_colour"}, int'(rd_colour), exp_c);
   endtask

   initial begin : stim
      int n;
      int seen;
      rst = 1; vga_plot = 0; vga_x = 0; vga_y = 0; vga_colour = 0;
      clear_start = 0; clear_colour = 0; rd_en = 0; rd_x = 0; rd_y = 0;
      repeat (3) tick();
      rst = 0;
      tick();
      cmp("rst_ready", int'(plot_ready), 1);
      cmp("rst_busy", int'(busy), 0);
      cmp("rst_pix", int'(pixel_count), 0);
      cmp("rst_drop", int'(drop_count), 0);

      // full clear to black, then corner reads
      clear_colour = 3'd0; clear_start = 1;
      tick();
      clear_start = 0;
      n = 0;
      while (!clear_done && n < 20000) begin
         tick();
         n = n + 1;
      end
      cmp("clear1_latency", n, 19200);
      read_px(0, 0, 0, "rd00");
      read_px(159, 119, 0, "rd159_119");

      // single plot while idle
      vga_plot = 1; vga_x = 80; vga_y = 60; vga_colour = 3'b010;
      tick();
      vga_plot = 0;
      cmp("plot1_busy", int'(busy), 1);
      tick();
      cmp("plot1_pix", int'(pixel_count), 1);
      cmp("plot1_idle", int'(busy), 0);
      read_px(80, 60, 2, "rd80_60");

      // FIFO full while reads hold the port
      rst = 1; tick(); tick(); rst = 0; tick();
      rd_en = 1; rd_x = 0; rd_y = 0;
      for (int i = 0; i < 9; i++) begin
         vga_plot = 1; vga_x = 8'(i + 10); vga_y = 7'd5; vga_colour = 3'(i);
         tick();
         if (i == 7) cmp("full_ready", int'(plot_ready), 0);
      end
      vga_plot = 0;
      cmp("full_drop", int'(drop_count), 1);
      rd_en = 0;
      repeat (8) tick();
      cmp("drain_pix", int'(pixel_count), 8);
      cmp("drain_busy", int'(busy), 0);
      read_px(17, 5, 7, "rd17_5");

      // out-of-range plot
      vga_plot = 1; vga_x = 160; vga_y = 0; vga_colour = 3'd5;
      tick();
      vga_plot = 0;
`ifdef PLOT_CAPTURE_CLIP_EN
      cmp("clip_drop", int'(drop_count), 2);
      cmp("clip_busy", int'(busy), 0);
      tick();
      cmp("clip_pix", int'(pixel_count), 8);
`else
      cmp("noclip_drop", int'(drop_count), 1);
      cmp("noclip_busy", int'(busy), 1);
      tick();
      cmp("noclip_pix", int'(pixel_count), 9);
`endif

      // drop counter saturation
      rd_en = 1; vga_plot = 1;
      repeat (300) tick();
      vga_plot = 0;
      cmp("drop_sat", int'(drop_count), 255);
      rd_en = 0;
      repeat (10) tick();

      // reset in the middle of a clear
      clear_colour = 3'd3; clear_start = 1;
      tick();
      clear_start = 0;
      repeat (100) tick();
      rst = 1;
      #1;
      cmp("abort_busy", int'(busy), 0);
      cmp("abort_ready", int'(plot_ready), 1);
      cmp("abort_pix", int'(pixel_count), 0);
      cmp("abort_drop", int'(drop_count), 0);
      cmp("abort_valid", int'(rd_valid), 0);
      cmp("abort_colour", int'(rd_colour), 0);
      tick(); tick();
      rst = 0;
      seen = 0;
      repeat (300) begin
         tick();
         if (clear_done) seen = seen + 1;
      end
      cmp("abort_no_done", seen, 0);
      read_px(50, 0, 3, "rd_partial");

      // random traffic
      repeat (3000) begin
         rand_inputs();
         tick();
      end

      // clear under random traffic with an ignored second request
      vga_plot = 0; rd_en = 0;
      clear_colour = 3'd6; clear_start = 1;
      tick();
      n = 0;
      while (n < 20000) begin
         rand_inputs();
         clear_start  = (n == 500);
         clear_colour = 3'd1;
         tick();
         n = n + 1;
         if (clear_done) break;
      end
      clear_start = 0;
      cmp("clear2_latency", n, 19200);

      repeat (2000) begin
         rand_inputs();
         tick();
      end
      vga_plot = 0; rd_en = 0;
      repeat (12) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
